wb_arbiter: RTL and testbench

Schedules the single scalar register-file write port between the ALU and the load unit. Each source pushes write requests through a valid/ready handshake into its own small FIFO, so neither source drops a result when both finish in the same cycle. One request per cycle is granted and driven as a registered register-file write. Load has fixed priority, bounded by an anti-starvation counter that guarantees ALU progress.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_req_fifo.sv | 57 +++++
 rtl/wb_arbiter.sv | 117 +++++++++++
 tb/tb_wb_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared writeback types: request entries, the register-file write bundle and
// the grant encoding used by the writeback arbiter.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_REG_W  = 5;

  typedef struct packed {
    logic [WB_REG_W-1:0]  reg_sel;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic                 s_rw_en;
    logic [WB_REG_W-1:0]  s_rw;
    logic [WB_DATA_W-1:0] s_wdata;
  } wb_out_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_LOAD
  } gnt_e;

endpackage

// File: rtl/wb_req_fifo.sv
// Small circular FIFO holding pending register-file write requests for one
// source; the head entry is visible combinationally for the arbiter.
module wb_req_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         push,
  input  logic                         pop,
  input  wb_req_t                      wdata,
  output wb_req_t                      head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wb_req_t        mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage needs no reset; validity is tracked by count alone.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates the single register-file write port between the ALU and the load
// unit: load wins by default, an anti-starvation counter forces ALU progress.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W       = WB_DATA_W,
  parameter int REG_W        = WB_REG_W,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [REG_W-1:0]  reg_sel_alu,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] dmemload,
  input  logic [REG_W-1:0]  reg_sel_load,
  output wb_out_t           wb_out,
  output logic              busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  wb_req_t          alu_req;
  wb_req_t          load_req;
  wb_req_t          alu_head;
  wb_req_t          load_head;
  wb_req_t          gnt_req;
  logic             alu_push;
  logic             alu_pop;
  logic             alu_full;
  logic             alu_empty;
  logic             load_push;
  logic             load_pop;
  logic             load_full;
  logic             load_empty;
  logic [CNT_W-1:0] alu_count;
  logic [CNT_W-1:0] load_count;
  logic             ready_en;
  logic [SW-1:0]    starve_cnt;
  gnt_e             gnt;

  assign alu_req  = '{reg_sel: reg_sel_alu, data: alu_out};
  assign load_req = '{reg_sel: reg_sel_load, data: dmemload};

  // ready_en holds both readies low until the first edge after reset releases.
  assign alu_ready  = ready_en && !alu_full;
  assign load_ready = ready_en && !load_full;
  assign alu_push   = alu_valid && alu_ready;
  assign load_push  = load_valid && load_ready;

  wb_req_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (alu_push),
    .pop   (alu_pop),
    .wdata (alu_req),
    .head  (alu_head),
    .full  (alu_full),
    .empty (alu_empty),
    .count (alu_count)
  );

  wb_req_fifo #(.DEPTH(FIFO_DEPTH)) u_load_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (load_push),
    .pop   (load_pop),
    .wdata (load_req),
    .head  (load_head),
    .full  (load_full),
    .empty (load_empty),
    .count (load_count)
  );

  always_comb begin
    gnt = GNT_NONE;
    if (!load_empty && !alu_empty)
      gnt = (starve_cnt == LIMIT) ? GNT_ALU : GNT_LOAD;
    else if (!load_empty)
      gnt = GNT_LOAD;
    else if (!alu_empty)
      gnt = GNT_ALU;
  end

  assign alu_pop  = (gnt == GNT_ALU);
  assign load_pop = (gnt == GNT_LOAD);
  assign gnt_req  = alu_pop ? alu_head : load_head;

  // Writes to register 0 still consume their grant slot but never enable the port.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wb_out     <= '0;
      starve_cnt <= '0;
      ready_en   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (gnt == GNT_NONE || gnt_req.reg_sel == '0)
        wb_out <= '0;
      else
        wb_out <= '{s_rw_en: 1'b1, s_rw: gnt_req.reg_sel, s_wdata: gnt_req.data};
      if (gnt == GNT_LOAD && !alu_empty) begin
        if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  assign busy = (alu_count != '0) || (load_count != '0) || wb_out.s_rw_en;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts each
// register-file write and its cycle; a monitor compares the registered output.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [31:0] alu_out = '0;
  logic [4:0]  reg_sel_alu = '0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] dmemload = '0;
  logic [4:0]  reg_sel_load = '0;
  wb_out_t     wb_out;
  logic        busy;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  wb_arbiter #(
    .DATA_W(32), .REG_W(5), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_out      (alu_out),
    .reg_sel_alu  (reg_sel_alu),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .dmemload     (dmemload),
    .reg_sel_load (reg_sel_load),
    .wb_out       (wb_out),
    .busy         (busy)
  );

  typedef struct {
    int          cyc;
    logic [4:0]  rs;
    logic [31:0] d;
  } exp_t;

  exp_t    expQ[$];
  wb_req_t aluQ[$];
  wb_req_t ldQ[$];
  int      starve = 0;
  bit      rdyEn = 0;
  bit      lastEn = 0;
  bit      lastRst = 1;
  bit      started = 0;
  bit      aluAcc = 0;
  int      vecCount = 0;
  int      missCount = 0;

  function automatic wb_req_t mk(input logic [4:0] r, input logic [31:0] d);
    wb_req_t q;
    q.reg_sel = r;
    q.data    = d;
    return q;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    vecCount++;
    if (act !== req) begin
      missCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // One clock of stimulus: check the state left by the previous edge, drive
  // new inputs, then advance the reference model across the coming edge.
  task automatic applyStimulus(input bit rst, input bit av, input wb_req_t ar,
                               input bit lv, input wb_req_t lr);
    bit      mAluRdy;
    bit      mLdRdy;
    bit      aluNe;
    int      gnt;
    wb_req_t g;
    @(negedge CLK);
    mAluRdy = rdyEn && (aluQ.size() < DEPTH);
    mLdRdy  = rdyEn && (ldQ.size() < DEPTH);
    if (started) begin
      checkOutput("alu_ready", 64'(alu_ready), 64'(mAluRdy));
      checkOutput("load_ready", 64'(load_ready), 64'(mLdRdy));
      checkOutput("busy", 64'(busy),
                  64'(aluQ.size() > 0 || ldQ.size() > 0 || lastEn));
      if (lastRst) checkOutput("wb_out_after_reset", 64'(wb_out), 64'd0);
    end
    RST          = rst;
    alu_valid    = av;
    alu_out      = ar.data;
    reg_sel_alu  = ar.reg_sel;
    load_valid   = lv;
    dmemload     = lr.data;
    reg_sel_load = lr.reg_sel;
    started = 1;
    lastRst = rst;
    if (rst) begin
      aluQ.delete();
      ldQ.delete();
      starve = 0;
      rdyEn  = 0;
      lastEn = 0;
      aluAcc = 0;
      return;
    end
    aluNe = aluQ.size() > 0;
    gnt = 0;
    if (aluQ.size() > 0 && ldQ.size() > 0) gnt = (starve == LIMIT) ? 1 : 2;
    else if (ldQ.size() > 0)                gnt = 2;
    else if (aluQ.size() > 0)               gnt = 1;
    g = '0;
    if (gnt == 1) g = aluQ.pop_front();
    if (gnt == 2) g = ldQ.pop_front();
    lastEn = (gnt != 0) && (g.reg_sel != 0);
    if (lastEn) expQ.push_back('{cyc + 1, g.reg_sel, g.data});
    starve = (gnt == 2 && aluNe) ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
    aluAcc = av && mAluRdy;
    if (aluAcc) aluQ.push_back(ar);
    if (lv && mLdRdy) ldQ.push_back(lr);
    rdyEn = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, '0);
  endtask

  // Monitor: every cycle, either the predicted write for this edge or silence.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
        e = expQ.pop_front();
        checkOutput("wb_en", 64'(wb_out.s_rw_en), 64'd1);
        checkOutput("wb_reg", 64'(wb_out.s_rw), 64'(e.rs));
        checkOutput("wb_data", 64'(wb_out.s_wdata), 64'(e.d));
      end else if (wb_out.s_rw_en === 1'b1) begin
        vecCount++;
        missCount++;
        $display("[TB] FAIL unexpected_write at cycle %0d: got reg %0d data %0h, expected no write",
                 cyc, wb_out.s_rw, wb_out.s_wdata);
      end
    end
  end

  initial begin
    wb_req_t a[3];
    int      idx;
    int      tries;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, '0, 0, '0);
    idle(2);

    applyStimulus(0, 1, mk(5'd1, 32'hADD00ADD), 0, '0);
    idle(4);

    applyStimulus(0, 1, mk(5'd3, 32'h12345678), 1, mk(5'd4, 32'hFEEDFADE));
    idle(4);

    for (int i = 0; i < 8; i++)
      applyStimulus(0, i == 0, mk(5'd9, 32'hA1A1_0009), 1, mk(5'(10 + i), 32'h1000 + i));
    idle(5);

    a[0] = mk(5'd6, 32'hA1);
    a[1] = mk(5'd7, 32'hA2);
    a[2] = mk(5'd8, 32'hA3);
    idx = 0;
    tries = 0;
    while (idx < 3 && tries < 20) begin
      applyStimulus(0, 1, a[idx], 0, '0);
      if (aluAcc) idx++;
      tries++;
    end
    if (idx < 3) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL alu_push_budget: got %0d accepted, expected 3", idx);
    end
    idle(4);

    applyStimulus(0, 0, '0, 1, mk(5'd0, 32'hDEADBEEF));
    applyStimulus(0, 0, '0, 1, mk(5'd2, 32'hDEADBEEF));
    idle(4);

    for (int i = 0; i < 6; i++)
      applyStimulus(0, 1, mk(5'(16 + i), $urandom), 1, mk(5'(24 + i), $urandom));
    applyStimulus(1, 1, mk(5'd5, 32'h5555), 1, mk(5'd6, 32'h6666));
    idle(6);

    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(0, 59) == 0,
                    1'($urandom_range(0, 1)), mk(5'($urandom_range(0, 31)), $urandom),
                    1'($urandom_range(0, 1)), mk(5'($urandom_range(0, 31)), $urandom));
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
